// File: rtl/ats21_host_if.sv
// ats21_host_if: client-side initiator for the ATS21 command interface.
// Upstream commands are queued in a small FIFO, issued one at a time on
// req/ctrlA/ctrlB with a req/ready handshake, and each answer (or a timeout
// abort) is returned upstream on the rsp_* channel. The alarm-finished
// vector on data is folded into a sticky, software-clearable register.
// Optional build macro: ATS_HOST_RETRY_EN (reissue on BUSY answers).
module ats21_host_if #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 64,
   parameter int MAX_RETRY  = 3,
   parameter int NUM_ALARMS = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [15:0]           cmd_a,
   input  logic [15:0]           cmd_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [1:0]            rsp_stat,
   output logic [NUM_ALARMS-1:0] rsp_data,
   output logic                  rsp_timeout,
   output logic [NUM_ALARMS-1:0] alarm_pending,
   input  logic [NUM_ALARMS-1:0] alarm_clr,
   output logic                  req,
   output logic [15:0]           ctrlA,
   output logic [15:0]           ctrlB,
   input  logic                  ready,
   input  logic [1:0]            stat,
   input  logic [NUM_ALARMS-1:0] data
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int WW = $clog2(TIMEOUT);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

   if (FIFO_DEPTH < 2 || TIMEOUT < 2 || MAX_RETRY < 0 || NUM_ALARMS < 1) begin : g_param_err
      $error("ats21_host_if: illegal parameter value");
   end

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
   } cmd_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   cmd_t            fifo_mem [FIFO_DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic            fifo_empty, fifo_full;
   logic            push, pop;
   cmd_t            head;
   logic [WW-1:0]   wcnt_q;
   logic            wcnt_clr, wcnt_inc;
   logic            cap_ok, cap_to;
   logic            retry_now, busy_retry;
   logic            reissue_q;

   // ---------------- command FIFO ----------------
   // Extra pointer MSB distinguishes full from empty.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign cmd_ready  = !fifo_full;
   assign push       = cmd_valid && !fifo_full;
   assign head       = fifo_mem[rd_ptr[AW-1:0]];

   // Storage array: written on push only, contents need no reset.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= '{a: cmd_a, b: cmd_b};
   end

   // Read/write pointers; reset flushes the queue.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // ---------------- BUSY reissue ----------------
`ifdef ATS_HOST_RETRY_EN
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RW-1:0] retry_cnt;

   // Reissues of the current command; a fresh pop starts over.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         retry_cnt <= '0;
      else if (pop)       retry_cnt <= '0;
      else if (retry_now) retry_cnt <= retry_cnt + RW'(1);
   end

   assign busy_retry = (stat == 2'b10) && (retry_cnt < RW'(MAX_RETRY));
`else
   assign busy_retry = 1'b0;
`endif

   // GAP that follows a reissue decision returns to REQ instead of IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) reissue_q <= 1'b0;
      else        reissue_q <= retry_now;
   end

   // ---------------- FSM ----------------
   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state and per-cycle control strobes.
   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      wcnt_clr  = 1'b0;
      wcnt_inc  = 1'b0;
      cap_ok    = 1'b0;
      cap_to    = 1'b0;
      retry_now = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               wcnt_clr = 1'b1;
               state_d  = S_REQ;
            end
         end
         S_REQ: begin
            if (ready) begin
               if (busy_retry) begin
                  retry_now = 1'b1;
                  state_d   = S_GAP;
               end else begin
                  cap_ok  = 1'b1;
                  state_d = S_RESP;
               end
            end else if (wcnt_q == WAIT_LAST) begin
               cap_to  = 1'b1;
               state_d = S_RESP;
            end else begin
               wcnt_inc = 1'b1;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = S_GAP;
         end
         S_GAP: begin
            if (reissue_q) begin
               wcnt_clr = 1'b1;
               state_d  = S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // req straight from the state register so reset drops it at once.
   assign req = (state_q == S_REQ);

   // Cycles spent waiting for ready on the current issue.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        wcnt_q <= '0;
      else if (wcnt_clr) wcnt_q <= '0;
      else if (wcnt_inc) wcnt_q <= wcnt_q + WW'(1);
   end

   // Command registers: loaded on pop, held until the next pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrlA <= '0;
         ctrlB <= '0;
      end else if (pop) begin
         ctrlA <= head.a;
         ctrlB <= head.b;
      end
   end

   // Response capture: ATS21 answer or timeout abort.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_stat    <= '0;
         rsp_data    <= '0;
         rsp_timeout <= 1'b0;
      end else if (cap_ok) begin
         rsp_stat    <= stat;
         rsp_data    <= data;
         rsp_timeout <= 1'b0;
      end else if (cap_to) begin
         rsp_stat    <= 2'b11;
         rsp_data    <= '0;
         rsp_timeout <= 1'b1;
      end
   end

   // Sticky alarms: data is an alarm vector only while ready is low;
   // a same-cycle set beats the clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      alarm_pending <= '0;
      else if (!ready) alarm_pending <= (alarm_pending & ~alarm_clr) | data;
      else             alarm_pending <= alarm_pending & ~alarm_clr;
   end

endmodule

// File: doc/ats21_host_if.md
Name: ats21_host_if

Overview:
- Client-side initiator for the ATS21 command interface. Buffers upstream commands in a small FIFO and drives req/ctrlA/ctrlB into the ATS21 with a request/ready handshake.
- Captures each ATS21 response (stat, data) and returns it upstream, with a timeout if ready never arrives.
- Separately accumulates the ATS21 alarm-finished vector into a sticky pending register for software.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
- TIMEOUT, 64, max cycles req is held waiting for ready before abort (>=2)
- MAX_RETRY, 3, reissue limit for BUSY responses (used only with ATS_HOST_RETRY_EN)
- NUM_ALARMS, 24, width of alarm vector / ATS21 data bus

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- cmd_valid  in  1  upstream command valid
- cmd_ready  out  1  FIFO can accept a command
- cmd_a  in  16  value for ctrlA
- cmd_b  in  16  value for ctrlB
- rsp_valid  out  1  response available
- rsp_ready  in  1  upstream accepts response
- rsp_stat  out  2  captured stat
- rsp_data  out  NUM_ALARMS  captured data
- rsp_timeout  out  1  response is a timeout abort
- alarm_pending  out  NUM_ALARMS  sticky alarm-finished bits
- alarm_clr  in  NUM_ALARMS  per-bit clear mask for alarm_pending
- req  out  1  to ATS21
- ctrlA  out  16  to ATS21
- ctrlB  out  16  to ATS21
- ready  in  1  from ATS21
- stat  in  2  from ATS21: 00 OK, 01 ERR, 10 BUSY, 11 reserved (passed through)
- data  in  NUM_ALARMS  from ATS21

Behaviour:
- Reset (reset==0, async):
  - req=0, ctrlA=ctrlB=0, rsp_valid=0, rsp_stat=0, rsp_data=0, rsp_timeout=0, alarm_pending=0.
  - FIFO flushed, so cmd_ready=1 after reset releases. FSM enters IDLE, counters cleared.
  - Reset mid-transaction drops req immediately; the in-flight command is lost and produces no response.
- FIFO:
  - Push when cmd_valid&&cmd_ready. cmd_ready = !full and does not depend on the same-cycle pop.
  - Push and pop in the same cycle are both honoured when not full.
- FSM states: IDLE, REQ, RESP, GAP.
  - IDLE: if FIFO non-empty, pop the head, register it into ctrlA/ctrlB, clear the wait counter, go to REQ. req=0.
  - REQ: req=1, ctrlA/ctrlB held stable.
    - If ready==1 at a posedge: capture stat->rsp_stat and data->rsp_data, rsp_timeout=0, go to RESP.
    - Else if the wait counter reaches TIMEOUT-1: rsp_timeout=1, rsp_stat=2'b11, rsp_data=0, go to RESP.
    - Else increment the counter.
  - RESP: req=0, rsp_valid=1 with fields held stable until rsp_ready==1; then go to GAP.
  - GAP: one cycle with req=0 (minimum req-low gap), then go to IDLE.
- Latency:
  - Command pushed at edge N into an empty FIFO with FSM in IDLE: req is high after edge N+1.
  - ready sampled at edge M: rsp_valid is high after edge M.
  - Back-to-back commands: req is low for at least 2 cycles (RESP + GAP).
- Alarm capture:
  - Every cycle where ready==0: alarm_pending <= (alarm_pending & ~alarm_clr) | data.
  - When ready==1, data carries a response, so alarm_pending only applies alarm_clr.
  - Set and clear on the same bit in the same cycle: set wins.
- ctrlA/ctrlB keep their last values outside REQ. Only req qualifies them.

Optional Feature:
- Macro: ATS_HOST_RETRY_EN.
- Defined:
  - A BUSY response (stat==2'b10, ready==1) with retry count < MAX_RETRY does not go to RESP. The FSM goes to GAP and then back to REQ with the same ctrlA/ctrlB, incrementing the retry count.
  - The wait counter restarts on each reissue.
  - Once the retry count reaches MAX_RETRY, the BUSY response is reported normally.
  - The retry count clears on each new pop.
- Not defined: BUSY is reported upstream like any other stat; no reissue.

Test Plan:
- Reset, push cmd_a=16'h8003, cmd_b=16'h0100; ATS21 model asserts ready 3 cycles after req with stat=00, data=24'h0000AB -> req high 1 cycle after push; rsp_valid with rsp_stat=00, rsp_data=24'h0000AB, rsp_timeout=0.
- Hold rsp_ready=0 and push 5 commands (FIFO_DEPTH=4) -> cmd_ready=0 after the FIFO fills (one entry already popped); no commands lost. Release rsp_ready -> 5 responses returned in order with matching ctrlA values.
- ATS21 model never asserts ready -> req high exactly 64 cycles, then rsp_valid with rsp_timeout=1, rsp_stat=11, rsp_data=0.
- data=24'h000005 for 2 cycles with ready=0, then alarm_clr=24'h000001 while data bit0=1 -> alarm_pending=24'h000005 (set wins). With data=0 and alarm_clr=24'h000004 -> alarm_pending=24'h000001.
- Drive reset=0 mid-REQ -> req=0 immediately and asynchronously, cmd_ready=1, no rsp_valid; the next command behaves as after a clean reset.
- With ATS_HOST_RETRY_EN and ATS21 answering BUSY 2 times then OK -> three req pulses with identical ctrlA/ctrlB and a single response with rsp_stat=00. Without the macro -> single response with rsp_stat=10.
